// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode codes,
// tag/size defaults and the operand record used for CDB capture.
package alu_rs_pkg;

  // Opcode codes shared with decode and the ALU.
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_BNE  = 6'd9;

  // ROB tag width (RBID range) and station depth defaults.
  localparam int RBID_W      = 4;
  localparam int RS_SIZE_DEF = 16;

  localparam logic [31:0] NULL32 = 32'h0;

  // One source operand: pending flag plus value (value valid when not pending).
  typedef struct packed {
    logic        pend;
    logic [31:0] val;
  } opnd_t;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder with a found flag. Used for free-slot
// allocation and for dispatch selection.
module rs_pick #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    // NOTE: defaults assigned first so every path drives found/idx and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued instructions, captures operands
// from the ALU and LSB result buses, and dispatches the lowest-index ready
// entry each cycle on a registered port.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = RBID_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,

  input  logic             issue_en,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_v1,
  input  logic [31:0]      issue_v2,
  input  logic             issue_p1,
  input  logic             issue_p2,
  input  logic [ROB_W-1:0] issue_q1,
  input  logic [ROB_W-1:0] issue_q2,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             rs_full,

  input  logic             cdb_alu_flag,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_flag,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_val,

  output logic             alu_flag,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [ROB_W-1:0] alu_rob
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage.
  logic [RS_SIZE-1:0] busy;
  logic [5:0]         op_q  [RS_SIZE];
  logic [31:0]        v1_q  [RS_SIZE];
  logic [31:0]        v2_q  [RS_SIZE];
  logic               p1_q  [RS_SIZE];
  logic               p2_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  opnd_t              wk1 [RS_SIZE];
  opnd_t              wk2 [RS_SIZE];
  opnd_t              ins1;
  opnd_t              ins2;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_found;
  logic [IDX_W-1:0]   disp_idx;
  logic               do_issue;

  // Capture an operand from the CDB; the ALU bus wins if both match.
  function automatic opnd_t snoop(input logic pend, input logic [ROB_W-1:0] tag,
                                  input logic [31:0] val);
    opnd_t r;
    r.pend = pend;
    r.val  = val;
    if (pend) begin
      if (cdb_alu_flag && cdb_alu_rob == tag) begin
        r.pend = 1'b0;
        r.val  = cdb_alu_val;
      end else if (cdb_lsb_flag && cdb_lsb_rob == tag) begin
        r.pend = 1'b0;
        r.val  = cdb_lsb_val;
      end
    end
    return r;
  endfunction

  assign rs_full  = &busy;
  assign do_issue = issue_en && !rs_full && free_found;

  // Readiness from registered state only, so a newly written or woken entry
  // waits one edge before it can be picked.
  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && !p1_q[i] && !p2_q[i];
      wk1[i]   = snoop(p1_q[i], q1_q[i], v1_q[i]);
      wk2[i]   = snoop(p2_q[i], q2_q[i], v2_q[i]);
    end
    ins1 = snoop(issue_p1, issue_q1, issue_v1);
    ins2 = snoop(issue_p2, issue_q2, issue_v2);
  end

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_disp_pick (
    .req   (ready),
    .found (disp_found),
    .idx   (disp_idx)
  );

  // Busy vector and registered dispatch port: flush, stall, issue, dispatch.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: state is updated with non-blocking assignments so every read in this edge sees pre-edge values.
    if (!rst_in) begin
      busy     <= '0;
      alu_flag <= 1'b0;
      alu_op   <= '0;
      alu_val1 <= NULL32;
      alu_val2 <= NULL32;
      alu_rob  <= '0;
    end else if (clear_in) begin
      busy     <= '0;
      alu_flag <= 1'b0;
      alu_op   <= '0;
      alu_val1 <= NULL32;
      alu_val2 <= NULL32;
      alu_rob  <= '0;
    end else if (rdy_in) begin
      alu_flag <= disp_found;
      alu_op   <= disp_found ? op_q[disp_idx]  : '0;
      alu_val1 <= disp_found ? v1_q[disp_idx]  : NULL32;
      alu_val2 <= disp_found ? v2_q[disp_idx]  : NULL32;
      alu_rob  <= disp_found ? rob_q[disp_idx] : '0;
      if (disp_found) busy[disp_idx] <= 1'b0;
      if (do_issue)   busy[free_idx] <= 1'b1;
    end else begin
      alu_flag <= 1'b0;
    end
  end

  // Entry payload: wakeup of pending busy entries and insertion of new ones.
  // NOTE: payload arrays carry no reset; busy qualifies every use, so stale contents are never observed.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          p1_q[i] <= wk1[i].pend;
          v1_q[i] <= wk1[i].val;
          p2_q[i] <= wk2[i].pend;
          v2_q[i] <= wk2[i].val;
        end
      end
      if (do_issue) begin
        op_q[free_idx]  <= issue_op;
        p1_q[free_idx]  <= ins1.pend;
        v1_q[free_idx]  <= ins1.val;
        p2_q[free_idx]  <= ins2.pend;
        v2_q[free_idx]  <= ins2.val;
        q1_q[free_idx]  <= issue_q1;
        q2_q[free_idx]  <= issue_q2;
        rob_q[free_idx] <= issue_rob;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: table of single-instruction vectors plus
// hand-written sequences for wakeup, full/order, flush, stall and reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        issue_en;
  logic [5:0]  issue_op;
  logic [31:0] issue_v1, issue_v2;
  logic        issue_p1, issue_p2;
  logic [3:0]  issue_q1, issue_q2, issue_rob;
  logic        rs_full;
  logic        cdb_alu_flag, cdb_lsb_flag;
  logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
  logic [31:0] cdb_alu_val, cdb_lsb_val;
  logic        alu_flag;
  logic [5:0]  alu_op;
  logic [31:0] alu_val1, alu_val2;
  logic [3:0]  alu_rob;

  int checks   = 0;
  int failures = 0;

  alu_rs #(.RS_SIZE(16), .ROB_W(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .issue_en     (issue_en),
    .issue_op     (issue_op),
    .issue_v1     (issue_v1),
    .issue_v2     (issue_v2),
    .issue_p1     (issue_p1),
    .issue_p2     (issue_p2),
    .issue_q1     (issue_q1),
    .issue_q2     (issue_q2),
    .issue_rob    (issue_rob),
    .rs_full      (rs_full),
    .cdb_alu_flag (cdb_alu_flag),
    .cdb_alu_rob  (cdb_alu_rob),
    .cdb_alu_val  (cdb_alu_val),
    .cdb_lsb_flag (cdb_lsb_flag),
    .cdb_lsb_rob  (cdb_lsb_rob),
    .cdb_lsb_val  (cdb_lsb_val),
    .alu_flag     (alu_flag),
    .alu_op       (alu_op),
    .alu_val1     (alu_val1),
    .alu_val2     (alu_val2),
    .alu_rob      (alu_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic        p1, p2;
    logic [3:0]  q1, q2, rob;
    logic        af;  logic [3:0] ar; logic [31:0] av;
    logic        lf;  logic [3:0] lr; logic [31:0] lv;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_en     = 1'b0;
    issue_p1     = 1'b0;
    issue_p2     = 1'b0;
    cdb_alu_flag = 1'b0;
    cdb_lsb_flag = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic p1, input logic [3:0] q1, input logic p2,
                       input logic [3:0] q2, input logic [3:0] rob);
    issue_en  = 1'b1;
    issue_op  = op;
    issue_v1  = v1;
    issue_v2  = v2;
    issue_p1  = p1;
    issue_q1  = q1;
    issue_p2  = p2;
    issue_q2  = q2;
    issue_rob = rob;
  endtask

  task automatic check_dispatch(input string name, input logic [5:0] op, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [3:0] rob);
    check({name, ".flag"}, 32'(alu_flag), 32'd1);
    check({name, ".op"},   32'(alu_op),   32'(op));
    check({name, ".val1"}, alu_val1,      v1);
    check({name, ".val2"}, alu_val2,      v2);
    check({name, ".rob"},  32'(alu_rob),  32'(rob));
  endtask

  initial begin
    // Vector table: op, v1, v2, p1, p2, q1, q2, rob, alu cdb, lsb cdb, expected v1/v2.
    vecs[0] = '{OP_ADD, 32'd5,  32'd7,  1'b0, 1'b0, 4'd0, 4'd0, 4'd3,
                1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  32'd5,      32'd7};
    vecs[1] = '{OP_XOR, 32'h21, 32'hFF, 1'b0, 1'b1, 4'd0, 4'd9, 4'd1,
                1'b1, 4'd9, 32'hABCD, 1'b0, 4'd0, 32'h0, 32'h21,    32'hABCD};
    vecs[2] = '{OP_SLL, 32'hEE, 32'd3,  1'b1, 1'b0, 4'd4, 4'd0, 4'd7,
                1'b0, 4'd0, 32'h0,  1'b1, 4'd4, 32'h55, 32'h55,     32'd3};
    vecs[3] = '{OP_BEQ, 32'h0,  32'h0,  1'b1, 1'b1, 4'd1, 4'd2, 4'd15,
                1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 32'h11,     32'h22};

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    issue_op = '0; issue_v1 = '0; issue_v2 = '0; issue_q1 = '0; issue_q2 = '0; issue_rob = '0;
    cdb_alu_rob = '0; cdb_alu_val = '0; cdb_lsb_rob = '0; cdb_lsb_val = '0;
    idle();
    step(); step();
    check("reset.flag",    32'(alu_flag), 32'd0);
    check("reset.full",    32'(rs_full),  32'd0);
    check("reset.val1",    alu_val1,      32'd0);
    check("reset.rob",     32'(alu_rob),  32'd0);
    rst_in = 1'b1;
    step();

    // Table: issue with same-cycle CDB, dispatch exactly one edge later.
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].p1, vecs[i].q1,
            vecs[i].p2, vecs[i].q2, vecs[i].rob);
      cdb_alu_flag = vecs[i].af; cdb_alu_rob = vecs[i].ar; cdb_alu_val = vecs[i].av;
      cdb_lsb_flag = vecs[i].lf; cdb_lsb_rob = vecs[i].lr; cdb_lsb_val = vecs[i].lv;
      step();
      idle();
      check($sformatf("vec%0d.early", i), 32'(alu_flag), 32'd0);
      step();
      check_dispatch($sformatf("vec%0d", i), vecs[i].op, vecs[i].e1, vecs[i].e2, vecs[i].rob);
      step();
      check($sformatf("vec%0d.after", i), 32'(alu_flag), 32'd0);
      check($sformatf("vec%0d.zero", i),  alu_val1,      32'd0);
    end

    // Wakeup from the LSB bus.
    issue(OP_SUB, 32'h0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
    step(); idle();
    step();
    check("wake.wait", 32'(alu_flag), 32'd0);
    cdb_lsb_flag = 1'b1; cdb_lsb_rob = 4'd6; cdb_lsb_val = 32'h10;
    step(); idle();
    check("wake.same_edge", 32'(alu_flag), 32'd0);
    step();
    check_dispatch("wake", OP_SUB, 32'h10, 32'd1, 4'd4);
    step();
    check("wake.after", 32'(alu_flag), 32'd0);

    // Full and ordering: 16 entries pending on tag 2.
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 32'h0, 32'(i + 100), 1'b1, 4'd2, 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    check("full.set",  32'(rs_full),  32'd1);
    check("full.idle", 32'(alu_flag), 32'd0);
    // Issue while full must be dropped.
    issue(OP_OR, 32'h1, 32'hDEAD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    step(); idle();
    step();
    check("full.drop", 32'(alu_flag), 32'd0);
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd2; cdb_alu_val = 32'h200;
    step(); idle();
    check("full.woken", 32'(rs_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      check_dispatch($sformatf("order%0d", i), OP_ADD, 32'h200, 32'(i + 100), 4'(i));
      if (i == 0) check("full.drop_after_first", 32'(rs_full), 32'd0);
    end
    step();
    check("order.end", 32'(alu_flag), 32'd0);

    // Flush in the same cycle as a CDB match.
    for (int i = 0; i < 4; i++) begin
      issue(OP_AND, 32'h0, 32'h3, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    clear_in = 1'b1;
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd7; cdb_alu_val = 32'h77;
    step();
    clear_in = 1'b0; idle();
    check("flush.flag", 32'(alu_flag), 32'd0);
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd7; cdb_alu_val = 32'h77;
    step(); idle();
    step();
    check("flush.no_dispatch", 32'(alu_flag), 32'd0);
    check("flush.full",        32'(rs_full),  32'd0);

    // Stall holds a ready entry for three cycles.
    issue(OP_BNE, 32'h9, 32'hA, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    step(); idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d", i), 32'(alu_flag), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    check_dispatch("stall.release", OP_BNE, 32'h9, 32'hA, 4'd5);
    step();
    check("stall.after", 32'(alu_flag), 32'd0);

    // Asynchronous reset in the middle of a dispatch.
    issue(OP_ADD, 32'h0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
    step();
    issue(OP_SRL, 32'h40, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    step(); idle();
    step();
    check_dispatch("rst.pre", OP_SRL, 32'h40, 32'h2, 4'd8);
    rst_in = 1'b0;
    #1;
    check("rst.flag", 32'(alu_flag), 32'd0);
    check("rst.full", 32'(rs_full),  32'd0);
    check("rst.rob",  32'(alu_rob),  32'd0);
    step();
    rst_in = 1'b1;
    cdb_alu_flag = 1'b1; cdb_alu_rob = 4'd3; cdb_alu_val = 32'h33;
    step(); idle();
    step();
    check("rst.entries_cleared", 32'(alu_flag), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the ALU in the Tomasulo core. It buffers decoded integer and branch instructions until both source operands are available, captures operands from the common data bus (CDB) broadcasts, and dispatches at most one ready instruction per cycle on the ALU's RS-side port. That port carries `val1`, `val2`, `flag`, `opcode` and `rob_reorder`. The block sits between the issue/decode stage and the ALU.

## Interface
- `RS_SIZE`, 16, number of entries (power of two).
- `ROB_W`, 4, ROB tag width; must equal the width of `RBID` in `defines.v`.
- `clk_in` input 1: clock.
- `rst_in` input 1: asynchronous reset, active-low.
- `rdy_in` input 1: global ready; low freezes all state.
- `clear_in` input 1: mispredict flush.
- `issue_en` input 1: an instruction is presented for insertion.
- `issue_op` input 6: opcode, encoded with the `defines.v` codes.
- `issue_v1`, `issue_v2` input 32: operand values, valid when the tag is not pending.
- `issue_p1`, `issue_p2` input 1: the operand is pending on a ROB tag.
- `issue_q1`, `issue_q2` input ROB_W: the tags being waited on.
- `issue_rob` input ROB_W: destination ROB entry.
- `rs_full` output 1: no free entry.
- `cdb_alu_flag` input 1, `cdb_alu_rob` input ROB_W, `cdb_alu_val` input 32: ALU result broadcast.
- `cdb_lsb_flag` input 1, `cdb_lsb_rob` input ROB_W, `cdb_lsb_val` input 32: load result broadcast.
- `alu_flag` output 1: dispatch valid, one cycle per instruction.
- `alu_op` output 6: opcode of the dispatched instruction.
- `alu_val1`, `alu_val2` output 32: operands of the dispatched instruction.
- `alu_rob` output ROB_W: ROB tag of the dispatched instruction.

## Operation
- Each entry holds: busy, op, v1, v2, p1, p2, q1, q2, rob.
- Ready means busy, with p1 and p2 both clear.
- **Issue:** when `issue_en` is high and `rs_full` is low, the instruction goes into the lowest-index free entry. `issue_en` while `rs_full` is high is a protocol violation and is ignored.
- **Issue-time forwarding:** if a pending tag matches a valid CDB broadcast in the same cycle, the entry stores that value with p cleared. The ALU bus has priority over the LSB bus; a tag never appears on both.
- **Wakeup:** every busy entry whose p1 or p2 is set compares its tag against both CDB buses each cycle. On a match it latches the value and clears p.
- **Dispatch:** the lowest-index ready entry is selected. It drives `alu_*` registered, `alu_flag` goes to 1, and the entry is freed at the same edge.
  - With no ready entry, `alu_flag` is 0 and `alu_op`, `alu_val1`, `alu_val2`, `alu_rob` are 0.
- **Same-cycle eligibility:**
  - An entry written or woken at edge E is first eligible for dispatch at edge E+1.
  - An entry freed by dispatch at edge E may be refilled by issue at edge E+1 at the earliest.
- **Flush:** `clear_in` has priority over everything. All entries go to not-busy and `alu_flag` goes to 0 at that edge; issue and CDB inputs in that cycle are discarded.
- **Stall:** while `rdy_in` is low (and `clear_in` is low), all entries and outputs hold their values. `alu_flag` is forced to 0 so no duplicate dispatch occurs.
- **Reset:** all entries are not-busy; `alu_flag`, `alu_op`, `alu_val1`, `alu_val2` and `alu_rob` are 0; `rs_full` is 0.

## Timing
- `rs_full` is combinational from the busy vector; it is 1 exactly when all `RS_SIZE` entries are busy.
- Issue with both operands ready at edge E gives `alu_flag`=1 after edge E+1. Minimum issue-to-ALU latency is 1 cycle.
- Wakeup at edge E gives dispatch after edge E+1 at the earliest.
- Throughput is 1 dispatch per cycle. Issue and dispatch may happen in the same cycle.
- Full boundary: with 16 busy entries and one dispatching at edge E, `rs_full` is low during the cycle after E.
- Reset is asynchronous assert; deassertion is synchronous to `clk_in` at system level.

## Structure
- `defines.v` (shared) holds:
  - the opcode codes;
  - the `RBID` range;
  - the `null32` constant;
  - a new `RS_SIZE` constant.
- Sub-module `rs_pick`: parameterised lowest-index priority encoder with a found flag. It is instantiated twice, once on ~busy (free slot) and once on ready (dispatch slot).
- All entry arrays are flops. No memory macro is used.

## Test plan
- **Ready issue:** issue ADD, v1=5, v2=7, no pending, rob=3 -> after next edge `alu_flag`=1, `alu_op`=ADD, `alu_val1`=5, `alu_val2`=7, `alu_rob`=3. The cycle after, `alu_flag`=0.
- **Wakeup:** issue SUB with p1=1, q1=6, v2=1 -> no dispatch. Then `cdb_lsb_flag`=1, rob=6, val=0x10 -> dispatch one cycle later with `alu_val1`=0x10, `alu_val2`=1.
- **Issue-time forwarding:** issue with q2=9 while `cdb_alu_flag`=1, rob=9, val=0xABCD in the same cycle -> dispatch after next edge with `alu_val2`=0xABCD.
- **Full / order:** fill 16 entries all pending on tag 2 -> `rs_full`=1. Broadcast tag 2 -> 16 consecutive dispatches in entry-index order 0..15, and `rs_full` drops after the first dispatch.
- **Flush:** 4 busy entries plus `clear_in` in the same cycle as a CDB match -> all entries freed, `alu_flag`=0, no later dispatch.
- **Stall and reset:** with `rdy_in`=0 for 3 cycles holding a ready entry -> no dispatch, then dispatch once `rdy_in`=1. Asserting `rst_in`=0 mid-dispatch -> `alu_flag`=0 immediately and `rs_full`=0.
